// File: rtl/pe_row_feeder_pkg.sv
// rtl/pe_row_feeder_pkg.sv - shared state encoding and row parameters for pe_row_feeder
package pe_row_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WGT,
    WGT_SETTLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_WEIGHT_WIDTH = 8;
  localparam int DEF_IFM_WIDTH    = 8;
  localparam int DEF_KERNEL_SIZE  = 3;
  localparam int DEF_IFM_LEN      = 16;
  localparam int DEF_PIPE_LAT     = 4;
  localparam int DEF_CNT_WIDTH    = 5;

  // Valid (fully overlapped) convolution outputs per row.
  function automatic int write_count(input int ifm_len, input int kernel_size);
    return ifm_len - kernel_size + 1;
  endfunction

endpackage

// File: rtl/pe_row_feeder_qual_shift.sv
// rtl/pe_row_feeder_qual_shift.sv - enable-gated shift register tracking which advances carry complete psums
module qual_shift #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr <= '0;
    end else if (en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        sr[i] <= sr[i-1];
      end
      sr[0] <= din;
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/pe_row_feeder.sv
// rtl/pe_row_feeder.sv - sequencer feeding kernel and IFM pixels to a 1-D convolution PE row
module pe_row_feeder
  import pe_row_feeder_pkg::*;
#(
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int IFM_WIDTH    = DEF_IFM_WIDTH,
  parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
  parameter int IFM_LEN      = DEF_IFM_LEN,
  parameter int PIPE_LAT     = DEF_PIPE_LAT,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  input  logic                              wgt_valid,
  output logic                              wgt_ready,
  input  logic [KERNEL_SIZE*WEIGHT_WIDTH-1:0] wgt_data,
  input  logic                              ifm_valid,
  output logic                              ifm_ready,
  input  logic [IFM_WIDTH-1:0]              ifm_data,
  output logic                              set_wgt,
  output logic [KERNEL_SIZE*WEIGHT_WIDTH-1:0] wgt,
  output logic                              set_ifm,
  output logic [IFM_WIDTH-1:0]              ifm,
  output logic                              set_reg,
  output logic                              wr_en
);

  localparam int DW = $clog2(PIPE_LAT + 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [DW-1:0]        drain_cnt;
  logic                 wgt_hs, ifm_hs, advance, row_start;
  logic                 qual_in, qual_out;

  assign busy      = (state != IDLE);
  assign wgt_ready = (state == LOAD_WGT);
  assign ifm_ready = (state == STREAM) && (cnt < CNT_WIDTH'(IFM_LEN));
  assign wgt_hs    = wgt_valid & wgt_ready;
  assign ifm_hs    = ifm_valid & ifm_ready;
  assign row_start = (state == IDLE) && start;

  // The PE row only moves on an advance, so a bubble freezes the whole psum chain.
  assign advance   = ((state == STREAM) && ifm_hs) || (state == DRAIN);
  assign qual_in   = (state == STREAM) && (cnt >= CNT_WIDTH'(KERNEL_SIZE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start) state_nxt = LOAD_WGT;
      LOAD_WGT:   if (wgt_hs) state_nxt = WGT_SETTLE;
      WGT_SETTLE: state_nxt = STREAM;
      STREAM:     if (ifm_hs && (cnt == CNT_WIDTH'(IFM_LEN - 1))) state_nxt = DRAIN;
      DRAIN:      if (drain_cnt == DW'(PIPE_LAT - 1)) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      drain_cnt <= '0;
    end else begin
      if (row_start) begin
        cnt <= '0;
      end else if (ifm_hs) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + DW'(1);
      end else begin
        drain_cnt <= '0;
      end
    end
  end

  qual_shift #(
    .DEPTH (PIPE_LAT)
  ) u_qual_shift (
    .clk  (clk),
    .rst  (rst),
    .clr  (row_start),
    .en   (advance),
    .din  (qual_in),
    .dout (qual_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      set_wgt <= 1'b0;
      wgt     <= '0;
      set_ifm <= 1'b0;
      ifm     <= '0;
      set_reg <= 1'b0;
      wr_en   <= 1'b0;
      done    <= 1'b0;
    end else begin
      set_wgt <= wgt_hs;
      if (wgt_hs) begin
        wgt <= wgt_data;
      end
      set_reg <= advance;
      set_ifm <= advance;
      wr_en   <= advance & qual_out;
      // Drain advances push zero pixels through so the tail psums complete.
      if (advance) begin
        ifm <= (state == STREAM) ? ifm_data : '0;
      end
      done    <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_pe_row_feeder.sv
// tb/tb_pe_row_feeder.sv - directed self-checking bench for pe_row_feeder
module tb_pe_row_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, wgt_valid, ifm_valid;
  logic [23:0] wgt_data;
  logic [7:0]  ifm_data;
  logic        busy, done, wgt_ready, ifm_ready, set_wgt, set_ifm, set_reg, wr_en;
  logic [23:0] wgt;
  logic [7:0]  ifm;

  logic        start2, wgt_valid2, ifm_valid2;
  logic [23:0] wgt_data2;
  logic [7:0]  ifm_data2;
  logic        busy2, done2, wgt_ready2, ifm_ready2, set_wgt2, set_ifm2, set_reg2, wr_en2;
  logic [23:0] wgt2;
  logic [7:0]  ifm2;

  logic [39:0] outs;
  assign outs = {busy, done, wgt_ready, ifm_ready, set_wgt, set_ifm, set_reg, wr_en, wgt, ifm};

  always #5 clk = ~clk;

  pe_row_feeder dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_data(ifm_data),
    .set_wgt(set_wgt), .wgt(wgt), .set_ifm(set_ifm), .ifm(ifm),
    .set_reg(set_reg), .wr_en(wr_en)
  );

  pe_row_feeder #(
    .IFM_LEN(3), .KERNEL_SIZE(3), .CNT_WIDTH(2)
  ) dut_min (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .wgt_valid(wgt_valid2), .wgt_ready(wgt_ready2), .wgt_data(wgt_data2),
    .ifm_valid(ifm_valid2), .ifm_ready(ifm_ready2), .ifm_data(ifm_data2),
    .set_wgt(set_wgt2), .wgt(wgt2), .set_ifm(set_ifm2), .ifm(ifm2),
    .set_reg(set_reg2), .wr_en(wr_en2)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-row observation of the default-parameter DUT, restarted at each set_wgt.
  int          n_set_wgt = 0;
  int          row_reg = 0, row_wr = 0, row_ifm = 0, orphan_wr = 0;
  int          last_wr_cyc = 0, done_cyc = 0;
  logic [31:0] wr_pat = '0;
  int          ifm_log [0:31];
  int          ifm_cyc [0:31];

  always @(negedge clk) begin
    if (set_wgt) begin
      n_set_wgt++;
      row_reg = 0; row_wr = 0; row_ifm = 0; wr_pat = '0;
    end
    if (set_ifm) begin
      if (row_ifm < 32) begin
        ifm_log[row_ifm] = int'(ifm);
        ifm_cyc[row_ifm] = cyc;
      end
      row_ifm++;
    end
    if (set_reg) begin
      if (wr_en && row_reg < 32) wr_pat[row_reg] = 1'b1;
      row_reg++;
    end
    if (wr_en) begin
      row_wr++;
      last_wr_cyc = cyc;
      if (!set_reg) orphan_wr++;
    end
    if (done) done_cyc = cyc;
  end

  int          reg2 = 0, wr2 = 0, last_wr2_cyc = 0, done2_cyc = 0;
  logic [31:0] pat2 = '0;

  always @(negedge clk) begin
    if (set_reg2) begin
      if (wr_en2 && reg2 < 32) pat2[reg2] = 1'b1;
      reg2++;
    end
    if (wr_en2) begin
      wr2++;
      last_wr2_cyc = cyc;
    end
    if (done2) done2_cyc = cyc;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input logic [23:0] kern, input int bubble, input int early,
                         input int start_at, input int abort_at, input int exp_delay);
    int   s, acc, guard;
    logic hs;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    check("wgt_ready_after_start", wgt_ready, 1);
    if (early) begin
      ifm_valid = 1'b1;
      ifm_data  = 8'hAA;
      check("ifm_ready_in_load_wgt", ifm_ready, 0);
    end
    wgt_valid = 1'b1;
    wgt_data  = kern;
    tick();
    wgt_valid = 1'b0;
    check("set_wgt_pulse", set_wgt, 1);
    check("wgt_value", wgt, kern);
    if (early) begin
      check("ifm_ready_in_settle", ifm_ready, 0);
      check("no_set_ifm_before_stream", set_ifm, 0);
      wgt_valid = 1'b1;
      wgt_data  = 24'hFFFFFF;
    end
    acc = 0;
    guard = 0;
    while (acc < 16 && guard < 200) begin
      if (abort_at > 0 && acc == abort_at) break;
      ifm_valid = 1'b1;
      ifm_data  = 8'(acc + 1);
      start     = (start_at > 0 && acc == start_at);
      hs        = ifm_ready;
      tick();
      guard++;
      if (start) check("busy_after_start_in_stream", busy, 1);
      start = 1'b0;
      if (hs) begin
        acc++;
        if (bubble && (acc == 3 || acc == 9)) begin
          ifm_valid = 1'b0;
          repeat (2) begin
            tick();
            check("bubble_set_reg", set_reg, 0);
            check("bubble_set_ifm", set_ifm, 0);
            check("bubble_wr_en", wr_en, 0);
          end
        end
      end
    end
    ifm_valid = 1'b0;
    wgt_valid = 1'b0;
    check("pixels_accepted", acc, (abort_at > 0) ? abort_at : 16);
    if (abort_at == 0) begin
      guard = 0;
      while (!done && guard < 100) begin
        tick();
        guard++;
      end
      check("done_seen", done, 1);
      check("row_cycles", cyc - s, exp_delay);
      check("busy_low_at_done", busy, 0);
      tick();
      check("done_one_cycle", done, 0);
      check("no_restart", busy, 0);
    end
  endtask

  task automatic check_row(input int exp_span);
    int bad_px, bad_tail;
    bad_px = 0;
    bad_tail = 0;
    for (int i = 0; i < 16; i++) if (ifm_log[i] != i + 1) bad_px++;
    for (int i = 16; i < 20; i++) if (ifm_log[i] != 0) bad_tail++;
    check("set_reg_count", row_reg, 20);
    check("set_ifm_count", row_ifm, 20);
    check("wr_en_count", row_wr, 14);
    check("wr_en_pattern", wr_pat, 32'h000F_FFC0);
    check("wr_without_set_reg", orphan_wr, 0);
    check("pixel_sequence", bad_px, 0);
    check("drain_pixels_zero", bad_tail, 0);
    check("pixel_span", ifm_cyc[15] - ifm_cyc[0], exp_span);
    check("done_after_last_wr", done_cyc - last_wr_cyc, 1);
  endtask

  initial begin
    int base, acc, guard;
    rst = 1'b1; start = 1'b1; wgt_valid = 1'b0; ifm_valid = 1'b0;
    wgt_data = '0; ifm_data = '0;
    start2 = 1'b0; wgt_valid2 = 1'b0; ifm_valid2 = 1'b0;
    wgt_data2 = '0; ifm_data2 = '0;

    repeat (3) begin
      tick();
      check("reset_outputs", outs, 0);
    end
    rst = 1'b0;
    tick();
    check("busy_after_reset_release", busy, 1);
    check("wgt_ready_after_reset_release", wgt_ready, 1);
    start = 1'b0;
    rst = 1'b1;
    tick();
    check("reset_from_load_wgt", outs, 0);
    rst = 1'b0;
    tick();

    base = n_set_wgt;
    run_row(24'h010203, 0, 0, 0, 0, 24);
    check_row(15);
    check("nominal_set_wgt_count", n_set_wgt - base, 1);

    run_row(24'h0A0B0C, 1, 0, 0, 0, 28);
    check_row(19);

    base = n_set_wgt;
    run_row(24'h112233, 0, 1, 5, 0, 24);
    check_row(15);
    check("wgt_held_outside_load", wgt, 24'h112233);
    check("handshake_set_wgt_count", n_set_wgt - base, 1);

    run_row(24'h445566, 0, 0, 0, 8, 0);
    rst = 1'b1;
    tick();
    check("midrow_reset_outputs", outs, 0);
    rst = 1'b0;
    tick();
    check("idle_after_midrow_reset", busy, 0);
    run_row(24'h778899, 0, 0, 0, 0, 24);
    check_row(15);

    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("min_wgt_ready", wgt_ready2, 1);
    wgt_valid2 = 1'b1;
    wgt_data2  = 24'h010101;
    tick();
    wgt_valid2 = 1'b0;
    acc = 0;
    guard = 0;
    while (acc < 3 && guard < 50) begin
      logic hs2;
      ifm_valid2 = 1'b1;
      ifm_data2  = 8'(acc + 5);
      hs2 = ifm_ready2;
      tick();
      guard++;
      if (hs2) acc++;
    end
    ifm_valid2 = 1'b0;
    guard = 0;
    while (!done2 && guard < 50) begin
      tick();
      guard++;
    end
    check("min_done_seen", done2, 1);
    tick();
    check("min_wr_count", wr2, 1);
    check("min_set_reg_count", reg2, 7);
    check("min_wr_pattern", pat2, 32'h0000_0040);
    check("min_done_after_wr", done2_cyc - last_wr2_cyc, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
